// File: rtl/triple_sample_voter.sv
// triple_sample_voter: serial-to-window front end for a 2-of-3 majority detector.
// A fill FSM (EMPTY/ONE/TWO/FULL) tracks how many valid samples the 3-deep sliding
// window holds. vote is the gated majority of the registered window, and count is a
// saturating tally of accepts that produced a full window voting 1.
// Optional build macro: TRIPLE_SAMPLE_VOTER_EDGE_EN adds a registered vote_rise pulse.
module triple_sample_voter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  input  logic             in,
  input  logic             clear,
  output logic             in0,
  output logic             in1,
  output logic             in2,
  output logic             full,
  output logic             vote,
  output logic [CNT_W-1:0] count
`ifdef TRIPLE_SAMPLE_VOTER_EDGE_EN
  ,
  output logic             vote_rise
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_r;
  logic             in0_r;
  logic             in1_r;
  logic             in2_r;
  logic             full_r;
  logic [CNT_W-1:0] count_r;

  logic             next_full_s;
  logic             maj_next_s;
  logic             vote_s;
  logic             inc_s;

  // 2-of-3 majority; written as an OR of pairwise ANDs so that a single
  // unknown sample cannot mask agreement between the other two.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

  // Next-window majority, fill look-ahead, current vote and counter enable.
  always_comb begin
    next_full_s = (state_r == ST_TWO) || (state_r == ST_FULL);
    maj_next_s  = maj3(in1_r, in2_r, in);
    vote_s      = full_r & maj3(in0_r, in1_r, in2_r);
    if (count_r != CNT_MAX) begin
      inc_s = next_full_s & maj_next_s;
    end else begin
      inc_s = 1'b0;
    end
  end

  // Fill FSM, sliding window shift and saturating vote counter.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_r <= ST_EMPTY;
      in0_r   <= 1'b0;
      in1_r   <= 1'b0;
      in2_r   <= 1'b0;
      full_r  <= 1'b0;
      count_r <= CNT_ZERO;
    end else if (in_val) begin
      in0_r <= in1_r;
      in1_r <= in2_r;
      in2_r <= in;
      case (state_r)
        ST_EMPTY: begin
          state_r <= ST_ONE;
          full_r  <= 1'b0;
        end
        ST_ONE: begin
          state_r <= ST_TWO;
          full_r  <= 1'b0;
        end
        ST_TWO: begin
          state_r <= ST_FULL;
          full_r  <= 1'b1;
        end
        ST_FULL: begin
          state_r <= ST_FULL;
          full_r  <= 1'b1;
        end
        default: begin
          state_r <= ST_EMPTY;
          full_r  <= 1'b0;
        end
      endcase
      if (inc_s) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end else begin
      state_r <= state_r;
      in0_r   <= in0_r;
      in1_r   <= in1_r;
      in2_r   <= in2_r;
      full_r  <= full_r;
      count_r <= count_r;
    end
  end

`ifdef TRIPLE_SAMPLE_VOTER_EDGE_EN
  logic vote_rise_r;

  // Register a one-cycle pulse when this accept turns the vote from 0 to 1.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vote_rise_r <= 1'b0;
    end else if (in_val) begin
      vote_rise_r <= next_full_s & maj_next_s & ~vote_s;
    end else begin
      vote_rise_r <= 1'b0;
    end
  end

  assign vote_rise = vote_rise_r;
`endif

  assign in0   = in0_r;
  assign in1   = in1_r;
  assign in2   = in2_r;
  assign full  = full_r;
  assign vote  = vote_s;
  assign count = count_r;

endmodule
